// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between the boot and CPU byte ports,
// granting round-robin (boot-only while booting) and sequencing strobe, done-wait and guard gap.
module uart_tx_arbiter #(
    parameter int TMO_W       = 16,
    parameter int TIMEOUT_CYC = 50000,
    parameter int GAP_CYC     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       booting,
    input  logic       boot_valid,
    input  logic [7:0] boot_data,
    output logic       boot_ready,
    input  logic       cpu_valid,
    input  logic [7:0] cpu_data,
    output logic       cpu_ready,
    output logic       uart_transmit,
    output logic [7:0] uart_txd_data,
    input  logic       uart_txd_done,
    input  logic       err_clr,
    output logic       busy,
    output logic       grant_id,
    output logic       timeout_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [1:0] S_AFTER = (GAP_CYC == 0) ? S_IDLE : S_GAP;

    logic [1:0]       r_state;
    logic [TMO_W-1:0] r_tmo;
    logic [GW-1:0]    r_gap;
    logic             r_last;
    logic             r_grant;
    logic             r_err;
    logic [7:0]       r_data;
    logic             w_idle;
    logic             w_sel_boot;
    logic             w_sel_cpu;
    logic             w_done;
    logic             w_tmo_hit;

    // r_last = 1 means the CPU had the last grant, so boot wins the next tie
    assign w_idle        = !rst && r_state == S_IDLE;
    assign w_sel_boot    = boot_valid && (booting || !cpu_valid || r_last);
    assign w_sel_cpu     = !booting && cpu_valid && (!boot_valid || !r_last);
    assign boot_ready    = w_idle && w_sel_boot;
    assign cpu_ready     = w_idle && w_sel_cpu;
    assign w_done        = r_state == S_WAIT && uart_txd_done;
    assign w_tmo_hit     = r_state == S_WAIT && !uart_txd_done && r_tmo == TMO_LAST;
    assign uart_transmit = r_state == S_SEND;
    assign busy          = r_state != S_IDLE;
    assign uart_txd_data = r_data;
    assign grant_id      = r_grant;
    assign timeout_err   = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tmo   <= '0;
            r_gap   <= '0;
            r_last  <= 1'b1;
            r_grant <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_err <= w_tmo_hit || (r_err && !err_clr);
            case (r_state)
                S_IDLE: begin
                    if (boot_ready || cpu_ready) begin
                        r_state <= S_SEND;
                        r_data  <= cpu_ready ? cpu_data : boot_data;
                        r_grant <= cpu_ready;
                        r_last  <= cpu_ready;
                    end
                end
                S_SEND: begin
                    r_state <= S_WAIT;
                    r_tmo   <= '0;
                end
                S_WAIT: begin
                    if (w_done || w_tmo_hit) begin
                        r_state <= S_AFTER;
                        r_gap   <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: begin
                    if (r_gap == GAP_LAST) r_state <= S_IDLE;
                    else r_gap <= r_gap + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized bench; the reference model tracks each byte as a timeline
// (accept cycle, strobe cycle, wait window, free-again cycle) rather than a state machine.
module tb_uart_tx_arbiter;
    localparam int TO  = 20;
    localparam int GAP = 2;

    logic       clk = 0, rst = 1, booting = 0;
    logic       boot_valid = 0, cpu_valid = 0, uart_txd_done = 0, err_clr = 0;
    logic [7:0] boot_data = 0, cpu_data = 0;
    logic       boot_ready, cpu_ready, uart_transmit, busy, grant_id, timeout_err;
    logic [7:0] uart_txd_data;

    uart_tx_arbiter #(.TMO_W(16), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst(rst), .booting(booting),
        .boot_valid(boot_valid), .boot_data(boot_data), .boot_ready(boot_ready),
        .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
        .uart_transmit(uart_transmit), .uart_txd_data(uart_txd_data),
        .uart_txd_done(uart_txd_done), .err_clr(err_clr),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0, k = 0;
    int m_free = 0, m_strobe = -1, m_lo = 1, m_hi = 0, m_done_cyc = -1, m_err_set = -1;
    logic [7:0] m_data = 0;
    logic m_grant = 0, m_last = 1, m_err = 0, m_init = 0, drop_b = 0, drop_c = 0;
    int p_boot = 0, p_cpu = 0, p_stray = 0, p_rst = 0, p_clr = 0, f_j = -1, f_cdata = -1;
    logic kb_rst = 1, kb_booting = 0, kb_clr = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, k);
        end
    endtask

    task automatic cycle();
        logic idle, e_br, e_cr;
        int j, e;
        @(negedge clk);
        if (drop_b) boot_valid = 0;
        if (drop_c) cpu_valid = 0;
        drop_b = 0;
        drop_c = 0;
        if (!boot_valid && $urandom_range(0, 99) < p_boot) begin
            boot_valid = 1;
            boot_data  = 8'($urandom);
        end
        if (!cpu_valid && $urandom_range(0, 99) < p_cpu) begin
            cpu_valid = 1;
            cpu_data  = (f_cdata >= 0) ? 8'(f_cdata) : 8'($urandom);
        end
        rst           = kb_rst || ($urandom_range(0, 999) < p_rst);
        booting       = kb_booting;
        err_clr       = kb_clr || ($urandom_range(0, 99) < p_clr);
        uart_txd_done = (k == m_done_cyc) || ($urandom_range(0, 99) < p_stray && (k < m_lo || k > m_hi));
        #1;
        idle = m_init && !rst && k >= m_free;
        if (booting) begin
            e_br = idle && boot_valid;
            e_cr = 0;
        end else if (boot_valid && cpu_valid) begin
            e_br = idle && m_last;
            e_cr = idle && !m_last;
        end else begin
            e_br = idle && boot_valid;
            e_cr = idle && cpu_valid;
        end
        if (m_init) begin
            chk("boot_ready", 8'(boot_ready), 8'(e_br));
            chk("cpu_ready", 8'(cpu_ready), 8'(e_cr));
            chk("uart_transmit", 8'(uart_transmit), 8'(k == m_strobe));
            chk("uart_txd_data", uart_txd_data, m_data);
            chk("busy", 8'(busy), 8'(k < m_free));
            chk("grant_id", 8'(grant_id), 8'(m_grant));
            chk("timeout_err", 8'(timeout_err), 8'(m_err));
        end
        if (rst) begin
            m_init = 1; m_free = k + 1; m_strobe = -1; m_lo = 1; m_hi = 0;
            m_done_cyc = -1; m_err_set = -1; m_data = 0; m_grant = 0; m_last = 1; m_err = 0;
        end else if (m_init) begin
            m_err = (k == m_err_set) || (m_err && !err_clr);
            if (e_br || e_cr) begin
                m_data  = e_cr ? cpu_data : boot_data;
                m_grant = e_cr;
                m_last  = e_cr;
                drop_b  = e_br;
                drop_c  = e_cr;
                // j = WAIT cycle (1-based) in which done arrives; 0 = never
                j = (f_j >= 0) ? f_j : ($urandom_range(0, 7) == 0) ? 0 :
                    ($urandom_range(0, 7) == 0) ? TO : $urandom_range(1, 6);
                e = (j == 0) ? k + 1 + TO : k + 1 + j;
                m_err_set  = (j == 0) ? e : -1;
                m_done_cyc = (j == 0) ? -1 : e;
                m_strobe = k + 1;
                m_lo     = k + 2;
                m_hi     = e;
                m_free   = e + 1 + GAP;
            end
        end
        k++;
    endtask

    initial begin
        repeat (3) cycle();
        kb_rst = 0;
        cycle();
        p_cpu = 100; f_cdata = 'h41; f_j = 10;
        cycle();
        p_cpu = 0; f_cdata = -1;
        repeat (20) cycle();
        p_boot = 100; p_cpu = 100; f_j = -1;
        repeat (80) cycle();
        kb_booting = 1;
        repeat (80) cycle();
        for (int i = 0; i < 100 && !(k > m_lo && k < m_hi); i++) cycle();
        chk("reach_wait", 8'(k > m_lo && k < m_hi), 8'd1);
        kb_booting = 0;
        repeat (30) cycle();
        p_boot = 0; p_cpu = 0;
        repeat (40) cycle();
        f_j = 0; p_cpu = 100;
        cycle();
        p_cpu = 0;
        repeat (30) cycle();
        kb_clr = 1;
        cycle();
        kb_clr = 0;
        repeat (3) cycle();
        f_j = TO; p_cpu = 100;
        cycle();
        p_cpu = 0;
        repeat (30) cycle();
        f_j = 0; p_cpu = 100;
        cycle();
        p_cpu = 0;
        repeat (6) cycle();
        kb_rst = 1;
        repeat (2) cycle();
        kb_rst = 0; p_stray = 100;
        cycle();
        p_stray = 0; f_j = 3; p_cpu = 100;
        cycle();
        p_cpu = 0;
        repeat (15) cycle();
        f_j = -1; p_stray = 10; p_rst = 3; p_clr = 5;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                kb_booting = ($urandom_range(0, 3) == 0);
                p_boot = $urandom_range(10, 100);
                p_cpu  = $urandom_range(10, 100);
            end
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
